// File: rtl/remote_unlock.sv
// rtl/remote_unlock.sv - 1-wire remote unlock receiver with code check, saf pulse and wrong-code lockout
module remote_unlock #(
    parameter int BIT_TICKS   = 4,
    parameter int SAF_CYCLES  = 2,
    parameter int LOCK_CYCLES = 64
) (
    input  logic       slow_clk,
    input  logic       drst,
    input  logic       rx,
    input  logic [3:0] remote_code,
    input  logic       close,
    output logic       saf,
    output logic       frame_err,
    output logic       lock,
    output logic [1:0] bad_count
);

    localparam int HALF     = BIT_TICKS / 2;
    localparam int HOLD_MAX = (LOCK_CYCLES > SAF_CYCLES) ? LOCK_CYCLES : SAF_CYCLES;
    localparam int TW       = $clog2(BIT_TICKS);
    localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [HW-1:0] HOLD_SAF  = HW'(SAF_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOCK = HW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK,
        PULSE,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [1:0]      sync;
    logic            rx_s;
    logic [TW-1:0]   tick;
    logic [HW-1:0]   hold;
    logic [1:0]      bit_idx;
    logic [3:0]      shreg;
    logic            par_bit;
    logic            stop_bit;
    logic            need_high;

    logic            bit_done;
    logic            frame_bad;
    logic            code_ok;
    logic            frame_err_next;
    logic [1:0]      bad_next;

    assign rx_s      = sync[1];
    assign bit_done  = (tick == TICK_LAST);
    assign frame_bad = (^{shreg, par_bit}) | ~stop_bit;
    assign code_ok   = (shreg == remote_code);

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    // FSM state register.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the CHECK decisions for frame_err and bad_count.
    always_comb begin
        state_next     = state;
        frame_err_next = 1'b0;
        bad_next       = bad_count;
        case (state)
            IDLE: begin
                if (!rx_s && !need_high) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick == TICK_HALF) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_idx == 2'd3)) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (frame_bad) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end else if (code_ok) begin
                    if (close) begin
                        bad_next   = 2'd0;
                        state_next = PULSE;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bad_count == 2'd2) begin
                    bad_next   = 2'd0;
                    state_next = LOCKED;
                end else begin
                    bad_next   = bad_count + 2'd1;
                    state_next = IDLE;
                end
            end
            PULSE: begin
                if (hold == HOLD_SAF) begin
                    state_next = IDLE;
                end
            end
            LOCKED: begin
                if (hold == HOLD_LOCK) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bit timing: tick restarts on every state change and at each bit boundary.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            tick <= '0;
        end else if ((state_next != state) || bit_done) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Hold counter times the saf pulse and the lockout from the state entry.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            hold <= '0;
        end else if (state_next != state) begin
            hold <= '0;
        end else begin
            hold <= hold + 1'b1;
        end
    end

    // Deserialiser: data LSB first, then parity and stop captured at mid-bit.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            bit_idx  <= 2'd0;
            shreg    <= 4'd0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b1;
        end else begin
            if (state != DATA) begin
                bit_idx <= 2'd0;
            end else if (bit_done) begin
                bit_idx <= bit_idx + 2'd1;
            end
            if ((state == DATA) && bit_done) begin
                shreg <= {rx_s, shreg[3:1]};
            end
            if ((state == PARITY) && bit_done) begin
                par_bit <= rx_s;
            end
            if ((state == STOP) && bit_done) begin
                stop_bit <= rx_s;
            end
        end
    end

    // After a lockout the line must be seen high before a new start edge counts.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            need_high <= 1'b0;
        end else if (state == LOCKED) begin
            need_high <= 1'b1;
        end else if (rx_s) begin
            need_high <= 1'b0;
        end
    end

    // Registered outputs derived from the next state and the CHECK decision.
    always_ff @(posedge slow_clk or posedge drst) begin
        if (drst) begin
            saf       <= 1'b0;
            frame_err <= 1'b0;
            lock      <= 1'b0;
            bad_count <= 2'd0;
        end else begin
            saf       <= (state_next == PULSE);
            frame_err <= frame_err_next;
            lock      <= (state_next == LOCKED);
            bad_count <= bad_next;
        end
    end

endmodule

// File: tb/tb_remote_unlock.sv
// tb/tb_remote_unlock.sv - scoreboard bench for remote_unlock
module tb_remote_unlock;

    localparam int BT = 4;
    localparam int SC = 2;
    localparam int LC = 64;

    logic       slow_clk = 1'b0;
    logic       drst = 1'b1;
    logic       rx = 1'b1;
    logic [3:0] remote_code = 4'b1010;
    logic       close = 1'b1;
    logic       saf;
    logic       frame_err;
    logic       lock;
    logic [1:0] bad_count;

    remote_unlock #(
        .BIT_TICKS  (BT),
        .SAF_CYCLES (SC),
        .LOCK_CYCLES(LC)
    ) dut (
        .slow_clk   (slow_clk),
        .drst       (drst),
        .rx         (rx),
        .remote_code(remote_code),
        .close      (close),
        .saf        (saf),
        .frame_err  (frame_err),
        .lock       (lock),
        .bad_count  (bad_count)
    );

    always #5 slow_clk = ~slow_clk;

    int cyc = 0;
    always @(posedge slow_clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    logic [4:0] prev = 5'b0;
    logic [4:0] cur;
    ev_t        got_e;

    // Monitor: every change of {saf, frame_err, lock, bad_count} must match the next expected event.
    always @(negedge slow_clk) begin
        cur = {saf, frame_err, lock, bad_count};
        if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %b at cycle %0d, required no change", cur, cyc);
            end else begin
                got_e = exp_q.pop_front();
                if ((got_e.vec !== cur) || (got_e.at != cyc)) begin
                    errors++;
                    $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                             cur, cyc, got_e.vec, got_e.at);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic push(input int at, input logic s, input logic fe, input logic lk, input logic [1:0] bc);
        ev_t e;
        e.at  = at;
        e.vec = {s, fe, lk, bc};
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge slow_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic st, output int k);
        logic [6:0] bits;
        bits = {st, p, d, 1'b0};
        k = cyc;
        for (int i = 0; i < 7; i++) begin
            rx = bits[i];
            repeat (BT) @(posedge slow_clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({saf, frame_err, lock, bad_count} !== 5'b0) begin
            errors++;
            $display("FAIL %s: got %b, required 00000", name, {saf, frame_err, lock, bad_count});
        end
    endtask

    task automatic good_frame();
        int k;
        send_frame(4'b1010, 1'b0, 1'b1, k);
        push(k + 30, 1'b1, 1'b0, 1'b0, 2'd0);
        push(k + 32, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_cyc(k + 45);
    endtask

    initial begin
        int k;
        int k3;

        repeat (3) @(posedge slow_clk);
        #1;
        check_zero("reset_state");
        drst = 1'b0;
        wait_cyc(10);

        // valid frame, safe locked
        good_frame();

        // valid frame, safe open: ignored
        close = 1'b0;
        send_frame(4'b1010, 1'b0, 1'b1, k);
        wait_cyc(k + 45);
        close = 1'b1;

        // parity error
        send_frame(4'b1010, 1'b1, 1'b1, k);
        push(k + 30, 1'b0, 1'b1, 1'b0, 2'd0);
        push(k + 31, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_cyc(k + 45);

        // stop-bit error
        send_frame(4'b1010, 1'b0, 1'b0, k);
        push(k + 30, 1'b0, 1'b1, 1'b0, 2'd0);
        push(k + 31, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_cyc(k + 45);

        // three wrong codes -> lockout
        send_frame(4'b0110, 1'b0, 1'b1, k);
        push(k + 30, 1'b0, 1'b0, 1'b0, 2'd1);
        wait_cyc(k + 45);
        send_frame(4'b0110, 1'b0, 1'b1, k);
        push(k + 30, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_cyc(k + 45);
        send_frame(4'b0110, 1'b0, 1'b1, k3);
        push(k3 + 30, 1'b0, 1'b0, 1'b1, 2'd0);
        push(k3 + 30 + LC, 1'b0, 1'b0, 1'b0, 2'd0);
        wait_cyc(k3 + 38);
        send_frame(4'b1010, 1'b0, 1'b1, k);
        // line held low across lockout exit must not start a frame
        wait_cyc(k3 + 80);
        rx = 1'b0;
        wait_cyc(k3 + 110);
        rx = 1'b1;
        wait_cyc(k3 + 120);
        good_frame();

        // one-cycle glitch: false start
        k = cyc;
        rx = 1'b0;
        @(posedge slow_clk);
        #1;
        rx = 1'b1;
        wait_cyc(k + 20);
        good_frame();

        // two wrong codes then the right one
        send_frame(4'b0110, 1'b0, 1'b1, k);
        push(k + 30, 1'b0, 1'b0, 1'b0, 2'd1);
        wait_cyc(k + 45);
        send_frame(4'b1111, 1'b0, 1'b1, k);
        push(k + 30, 1'b0, 1'b0, 1'b0, 2'd2);
        wait_cyc(k + 45);
        good_frame();

        // reset during DATA with a non-zero bad_count
        send_frame(4'b0001, 1'b1, 1'b1, k);
        push(k + 30, 1'b0, 1'b0, 1'b0, 2'd1);
        wait_cyc(k + 45);
        k = cyc;
        rx = 1'b0;
        wait_cyc(k + 8);
        rx = 1'b1;
        wait_cyc(k + 10);
        drst = 1'b1;
        push(cyc, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        check_zero("reset_in_data");
        @(posedge slow_clk);
        #1;
        drst = 1'b0;
        wait_cyc(cyc + 10);

        // reset during PULSE
        send_frame(4'b1010, 1'b0, 1'b1, k);
        push(k + 30, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_cyc(k + 31);
        drst = 1'b1;
        push(k + 31, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        check_zero("reset_in_pulse");
        @(posedge slow_clk);
        #1;
        drst = 1'b0;
        wait_cyc(cyc + 10);
        good_frame();

        wait_cyc(cyc + 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events not seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
